// File: rtl/cancid_stream_ctx_pkg.sv
// Shared types and defaults for the CANCID per-stream context manager.
// Holds the FSM state enum, default widths and the saturating add.
package cancid_pkg;

  localparam int CANCID_STATE_W     = 11;
  localparam int CANCID_NUM_STREAMS = 64;
  localparam int CANCID_COUNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ACTIVE,
    COMMIT
  } ctx_state_e;

  // Adds inc to a w-bit value, sticking at 2^w-1 (w up to 31).
  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic        inc,
    input int          w
  );
    logic [31:0] maxv;
    maxv = (32'h1 << w) - 32'h1;
    if (a >= maxv) return maxv;
    return a + {31'd0, inc};
  endfunction

endpackage

// File: rtl/cancid_stream_ctx_if.sv
// Bundle between front end / matcher (master) and context manager (slave).
// Carries load/eop control, matcher state, match flag, counts and readback.
interface cancid_stream_ctx_if
  import cancid_pkg::*;
#(
  parameter int STATE_W = CANCID_STATE_W,
  parameter int SID_W   = $clog2(CANCID_NUM_STREAMS),
  parameter int COUNT_W = CANCID_COUNT_W
);
  logic               load_state;
  logic               new_stream_id;
  logic [SID_W-1:0]   stream_id;
  logic               enable;
  logic               eop;
  logic [STATE_W-1:0] m_state_out;
  logic               m_accept;
  logic [STATE_W-1:0] m_state_in;
  logic               m_state_in_vld;
  logic               fired;
  logic [COUNT_W-1:0] count;
  logic               ctx_overwrite;
  logic               rd_req;
  logic [SID_W-1:0]   rd_sid;
  logic [COUNT_W-1:0] rd_count;
  logic               rd_vld;

  modport master (
    output load_state, new_stream_id, stream_id,
    output enable, eop, m_state_out, m_accept,
    output rd_req, rd_sid,
    input  m_state_in, m_state_in_vld, fired,
    input  count, ctx_overwrite, rd_count, rd_vld
  );

  modport slave (
    input  load_state, new_stream_id, stream_id,
    input  enable, eop, m_state_out, m_accept,
    input  rd_req, rd_sid,
    output m_state_in, m_state_in_vld, fired,
    output count, ctx_overwrite, rd_count, rd_vld
  );
endinterface

// File: rtl/cancid_ctx_ram.sv
// 1W1R synchronous matcher-state memory, N x W, no reset.
// Ports: clk, we/waddr/wdata write; raddr -> rdata next cycle, write bypassed.
module cancid_ctx_ram
  import cancid_pkg::*;
#(
  parameter int W  = CANCID_STATE_W,
  parameter int N  = CANCID_NUM_STREAMS,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
  end
endmodule

// File: rtl/cancid_stream_ctx.sv
// Per-stream save/restore of one CANCID matcher with end-of-packet count commit.
// Ports: clk, rst (async high), bus (slave). Macro CANCID_PER_STREAM_COUNT_EN.
module cancid_stream_ctx
  import cancid_pkg::*;
#(
  parameter int STATE_W     = CANCID_STATE_W,
  parameter int NUM_STREAMS = CANCID_NUM_STREAMS,
  parameter int SID_W       = $clog2(NUM_STREAMS),
  parameter int COUNT_W     = CANCID_COUNT_W
) (
  input logic                clk,
  input logic                rst,
  cancid_stream_ctx_if.slave bus
);
  ctx_state_e             st;
  logic [SID_W-1:0]       sid_q;
  logic                   zero_q;
  logic                   en_q;
  logic [STATE_W-1:0]     cap_q;
  logic [NUM_STREAMS-1:0] valid_q;
  logic                   vld_q;
  logic                   fired_q;
  logic                   ovw_q;
  logic [COUNT_W-1:0]     cnt_q;
  logic [STATE_W-1:0]     rdata;
  logic [COUNT_W-1:0]     cnt_base;
  logic [COUNT_W-1:0]     cnt_nxt;
  logic                   busy;

  logic start;
  logic commit_we;
  logic byp_hit;
  logic zero_nxt;

  assign start     = bus.load_state && !busy;
  assign commit_we = (st == COMMIT) && en_q;
  // A commit this cycle sets valid at the same edge the load decides zero.
  assign byp_hit   = commit_we && (sid_q == bus.stream_id);
  assign zero_nxt  = bus.new_stream_id ||
                     !(valid_q[bus.stream_id] || byp_hit);
  assign cnt_nxt   = COUNT_W'(sat_add(32'(cnt_base), fired_q, COUNT_W));

  cancid_ctx_ram #(
    .W  (STATE_W),
    .N  (NUM_STREAMS),
    .AW (SID_W)
  ) u_ram (
    .clk   (clk),
    .we    (commit_we),
    .waddr (sid_q),
    .wdata (cap_q),
    .raddr (bus.stream_id),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= IDLE;
      sid_q   <= '0;
      zero_q  <= 1'b1;
      en_q    <= 1'b0;
      cap_q   <= '0;
      valid_q <= '0;
      vld_q   <= 1'b0;
      fired_q <= 1'b0;
      ovw_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      vld_q <= 1'b0;
      ovw_q <= 1'b0;
      unique case (st)
        IDLE: begin
          if (start) begin
            st      <= LOAD;
            sid_q   <= bus.stream_id;
            zero_q  <= zero_nxt;
            vld_q   <= 1'b1;
            fired_q <= 1'b0;
          end
        end
        LOAD: st <= ACTIVE;
        ACTIVE: begin
          if (bus.eop) begin
            st      <= COMMIT;
            cap_q   <= bus.m_state_out;
            en_q    <= bus.enable;
            fired_q <= fired_q | bus.m_accept;
          end else if (start) begin
            st      <= LOAD;
            sid_q   <= bus.stream_id;
            zero_q  <= zero_nxt;
            vld_q   <= 1'b1;
            fired_q <= 1'b0;
          end else begin
            fired_q <= fired_q | bus.m_accept;
          end
        end
        COMMIT: begin
          if (en_q) begin
            valid_q[sid_q] <= 1'b1;
            ovw_q <= (cap_q == '0) && valid_q[sid_q];
            cnt_q <= cnt_nxt;
          end else begin
            fired_q <= 1'b0;
          end
          if (start) begin
            st      <= LOAD;
            sid_q   <= bus.stream_id;
            zero_q  <= zero_nxt;
            vld_q   <= 1'b1;
            fired_q <= 1'b0;
          end else begin
            st <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.m_state_in     = (st == LOAD && !zero_q) ? rdata : '0;
  assign bus.m_state_in_vld = vld_q;
  assign bus.fired          = fired_q;
  assign bus.count          = cnt_q;
  assign bus.ctx_overwrite  = ovw_q;

`ifdef CANCID_PER_STREAM_COUNT_EN
  logic [COUNT_W-1:0] cnt_mem [NUM_STREAMS];
  logic [SID_W-1:0]   sw_idx;
  logic [COUNT_W-1:0] rd_cnt_q;
  logic               rd_vld_q;

  // Count RAM has no reset port; clear it one entry per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b1;
      sw_idx   <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= bus.rd_req;
      if (busy) begin
        sw_idx <= sw_idx + 1'b1;
        if (sw_idx == SID_W'(NUM_STREAMS - 1)) busy <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (busy) cnt_mem[sw_idx] <= '0;
    else if (commit_we) cnt_mem[sid_q] <= cnt_nxt;
    rd_cnt_q <= cnt_mem[bus.rd_sid];
  end

  assign cnt_base     = cnt_mem[sid_q];
  assign bus.rd_count = rd_cnt_q;
  assign bus.rd_vld   = rd_vld_q;
`else
  logic unused_rd;
  assign unused_rd    = ^{bus.rd_req, bus.rd_sid};
  assign busy         = 1'b0;
  assign cnt_base     = cnt_q;
  assign bus.rd_count = '0;
  assign bus.rd_vld   = 1'b0;
`endif

endmodule

// File: tb/tb_cancid_stream_ctx.sv
// Directed bench for cancid_stream_ctx: load/commit/bypass/abort/saturate.
// A second narrow instance (COUNT_W=2) exercises count saturation.
module tb_cancid_stream_ctx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  cancid_stream_ctx_if #(.STATE_W(11), .SID_W(6), .COUNT_W(16)) bif();
  cancid_stream_ctx_if #(.STATE_W(4), .SID_W(2), .COUNT_W(2)) sif();

  cancid_stream_ctx #(
    .STATE_W(11), .NUM_STREAMS(64), .SID_W(6), .COUNT_W(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  cancid_stream_ctx #(
    .STATE_W(4), .NUM_STREAMS(4), .SID_W(2), .COUNT_W(2)
  ) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_pkt(input logic [5:0] sid, input logic nsid);
    bif.load_state    = 1'b1;
    bif.stream_id     = sid;
    bif.new_stream_id = nsid;
    tick();
    bif.load_state    = 1'b0;
    bif.new_stream_id = 1'b0;
  endtask

  task automatic eop_cycle(input logic [10:0] s, input logic acc,
                           input logic en);
    bif.m_state_out = s;
    bif.m_accept    = acc;
    bif.enable      = en;
    bif.eop         = 1'b1;
    tick();
    bif.eop      = 1'b0;
    bif.m_accept = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (70) tick();
  endtask

  task automatic test_reset;
    bif.load_state = 0; bif.new_stream_id = 0; bif.stream_id = 0;
    bif.enable = 0; bif.eop = 0; bif.m_state_out = 0; bif.m_accept = 0;
    bif.rd_req = 0; bif.rd_sid = 0;
    sif.load_state = 0; sif.new_stream_id = 0; sif.stream_id = 0;
    sif.enable = 0; sif.eop = 0; sif.m_state_out = 0; sif.m_accept = 0;
    sif.rd_req = 0; sif.rd_sid = 0;
    do_reset();
    checks++;
    if (bif.fired !== 1'b0 || bif.count !== 16'd0 ||
        bif.m_state_in_vld !== 1'b0 || bif.m_state_in !== 11'd0 ||
        bif.ctx_overwrite !== 1'b0 || bif.rd_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got f=%b c=%h v=%b s=%h o=%b r=%b exp zeros",
        bif.fired, bif.count, bif.m_state_in_vld, bif.m_state_in,
        bif.ctx_overwrite, bif.rd_vld);
    end
  endtask

  task automatic test_invalid_load;
    start_pkt(6'd5, 1'b0);
    checks++;
    if (bif.m_state_in_vld !== 1'b1 || bif.m_state_in !== 11'd0) begin
      errors++;
      $display("FAIL invalid_load got vld=%b st=%h exp 1/000",
        bif.m_state_in_vld, bif.m_state_in);
    end
    tick();
    checks++;
    if (bif.m_state_in_vld !== 1'b0) begin
      errors++;
      $display("FAIL vld_one_cycle got %b exp 0", bif.m_state_in_vld);
    end
    eop_cycle(11'h7FF, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_commit_restore;
    start_pkt(6'd3, 1'b1);
    tick();
    bif.m_accept = 1'b1;
    tick();
    bif.m_accept = 1'b0;
    checks++;
    if (bif.fired !== 1'b1) begin
      errors++;
      $display("FAIL fired_set got %b exp 1", bif.fired);
    end
    eop_cycle(11'h2A5, 1'b0, 1'b1);
    tick();
    checks++;
    if (bif.count !== 16'd1) begin
      errors++;
      $display("FAIL count_one got %h exp 0001", bif.count);
    end
    start_pkt(6'd3, 1'b0);
    checks++;
    if (bif.m_state_in !== 11'h2A5 || bif.fired !== 1'b0) begin
      errors++;
      $display("FAIL restore got st=%h f=%b exp 2a5/0",
        bif.m_state_in, bif.fired);
    end
  endtask

  task automatic test_disabled;
    tick();
    eop_cycle(11'h111, 1'b1, 1'b0);
    checks++;
    if (bif.fired !== 1'b1) begin
      errors++;
      $display("FAIL fired_hold got %b exp 1", bif.fired);
    end
    tick();
    checks++;
    if (bif.count !== 16'd1 || bif.fired !== 1'b0) begin
      errors++;
      $display("FAIL disabled got c=%h f=%b exp 0001/0",
        bif.count, bif.fired);
    end
    start_pkt(6'd3, 1'b0);
    checks++;
    if (bif.m_state_in !== 11'h2A5) begin
      errors++;
      $display("FAIL disabled_mem got %h exp 2a5", bif.m_state_in);
    end
  endtask

  task automatic test_bypass;
    tick();
    eop_cycle(11'h155, 1'b0, 1'b1);
    bif.load_state = 1'b1;
    bif.stream_id  = 6'd3;
    tick();
    bif.load_state = 1'b0;
    checks++;
    if (bif.m_state_in !== 11'h155 || bif.m_state_in_vld !== 1'b1) begin
      errors++;
      $display("FAIL bypass got st=%h vld=%b exp 155/1",
        bif.m_state_in, bif.m_state_in_vld);
    end
  endtask

  task automatic test_abort;
    tick();
    bif.m_accept = 1'b1;
    tick();
    bif.m_accept = 1'b0;
    bif.load_state = 1'b1;
    bif.stream_id  = 6'd3;
    tick();
    bif.load_state = 1'b0;
    checks++;
    if (bif.fired !== 1'b0 || bif.m_state_in !== 11'h155 ||
        bif.count !== 16'd1) begin
      errors++;
      $display("FAIL abort got f=%b st=%h c=%h exp 0/155/0001",
        bif.fired, bif.m_state_in, bif.count);
    end
  endtask

  task automatic test_overwrite;
    tick();
    eop_cycle(11'h000, 1'b0, 1'b1);
    tick();
    checks++;
    if (bif.ctx_overwrite !== 1'b1) begin
      errors++;
      $display("FAIL overwrite got %b exp 1", bif.ctx_overwrite);
    end
    tick();
    checks++;
    if (bif.ctx_overwrite !== 1'b0) begin
      errors++;
      $display("FAIL overwrite_pulse got %b exp 0", bif.ctx_overwrite);
    end
  endtask

  task automatic test_eop_ignored;
    bif.m_state_out = 11'h3FF;
    bif.m_accept = 1'b1;
    bif.enable = 1'b1;
    bif.eop = 1'b1;
    tick();
    bif.eop = 1'b0;
    bif.m_accept = 1'b0;
    tick();
    tick();
    checks++;
    if (bif.count !== 16'd1 || bif.fired !== 1'b0 ||
        bif.m_state_in_vld !== 1'b0) begin
      errors++;
      $display("FAIL eop_idle got c=%h f=%b v=%b exp 0001/0/0",
        bif.count, bif.fired, bif.m_state_in_vld);
    end
  endtask

  task automatic test_readback;
    logic [15:0] exp_c [3];
`ifdef CANCID_PER_STREAM_COUNT_EN
    exp_c = '{16'd1, 16'd1, 16'd2};
`else
    exp_c = '{16'd2, 16'd3, 16'd4};
`endif
    start_pkt(6'd7, 1'b1);
    tick();
    eop_cycle(11'h007, 1'b1, 1'b1);
    tick();
    checks++;
    if (bif.count !== exp_c[0]) begin
      errors++;
      $display("FAIL count_sid7 got %h exp %h", bif.count, exp_c[0]);
    end
    for (int k = 0; k < 2; k++) begin
      start_pkt(6'd9, 1'b0);
      tick();
      eop_cycle(11'h009, 1'b1, 1'b1);
      tick();
      checks++;
      if (bif.count !== exp_c[k+1]) begin
        errors++;
        $display("FAIL count_sid9_%0d got %h exp %h",
          k, bif.count, exp_c[k+1]);
      end
    end
    bif.rd_req = 1'b1;
    bif.rd_sid = 6'd9;
    tick();
`ifdef CANCID_PER_STREAM_COUNT_EN
    checks++;
    if (bif.rd_vld !== 1'b1 || bif.rd_count !== 16'd2) begin
      errors++;
      $display("FAIL rd_sid9 got v=%b c=%h exp 1/0002",
        bif.rd_vld, bif.rd_count);
    end
    bif.rd_sid = 6'd7;
    tick();
    bif.rd_req = 1'b0;
    checks++;
    if (bif.rd_count !== 16'd1) begin
      errors++;
      $display("FAIL rd_sid7 got %h exp 0001", bif.rd_count);
    end
    tick();
    checks++;
    if (bif.rd_vld !== 1'b0) begin
      errors++;
      $display("FAIL rd_vld_drop got %b exp 0", bif.rd_vld);
    end
`else
    bif.rd_req = 1'b0;
    checks++;
    if (bif.rd_vld !== 1'b0 || bif.rd_count !== 16'd0) begin
      errors++;
      $display("FAIL rd_tied got v=%b c=%h exp 0/0000",
        bif.rd_vld, bif.rd_count);
    end
`endif
  endtask

  task automatic test_saturation;
    logic [1:0] exp_t [4];
    exp_t = '{2'd1, 2'd2, 2'd3, 2'd3};
    for (int i = 0; i < 4; i++) begin
      sif.load_state = 1'b1;
      sif.stream_id  = 2'd1;
      tick();
      sif.load_state = 1'b0;
      tick();
      sif.m_state_out = 4'(i + 1);
      sif.m_accept = 1'b1;
      sif.enable = 1'b1;
      sif.eop = 1'b1;
      tick();
      sif.eop = 1'b0;
      sif.m_accept = 1'b0;
      tick();
      checks++;
      if (sif.count !== exp_t[i]) begin
        errors++;
        $display("FAIL saturate_%0d got %0d exp %0d",
          i, sif.count, exp_t[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    start_pkt(6'd3, 1'b0);
    tick();
    bif.m_accept = 1'b1;
    tick();
    bif.m_accept = 1'b0;
    checks++;
    if (bif.fired !== 1'b1) begin
      errors++;
      $display("FAIL mid_fired got %b exp 1", bif.fired);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bif.fired !== 1'b0 || bif.count !== 16'd0 ||
        sif.count !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset got f=%b c=%h sc=%0d exp 0/0000/0",
        bif.fired, bif.count, sif.count);
    end
    tick();
    rst = 1'b0;
    repeat (70) tick();
    start_pkt(6'd3, 1'b0);
    checks++;
    if (bif.m_state_in !== 11'd0 || bif.m_state_in_vld !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_load got st=%h v=%b exp 000/1",
        bif.m_state_in, bif.m_state_in_vld);
    end
    tick();
    eop_cycle(11'h000, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    test_reset();
    test_invalid_load();
    test_commit_restore();
    test_disabled();
    test_bypass();
    test_abort();
    test_overwrite();
    test_eop_ignored();
    test_readback();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
